// File: rtl/br_pkg.sv
// br_pkg: shared FSM state, funct3 encodings and helpers for the branch controller
package br_pkg;
  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT, FLUSH} br_state_t;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  function automatic logic is_illegal_f3(input logic [2:0] f3);
    return f3[2:1] == 2'b01;
  endfunction
endpackage

// File: rtl/branch_comp.sv
// branch_comp: operand comparator (A, B, BrUn in; Eq, Lt out), signed or unsigned less-than
module branch_comp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            BrUn,
  output logic            Eq,
  output logic            Lt
);
  always_comb begin
    Eq = A == B;
    Lt = BrUn ? (A < B) : ($signed(A) < $signed(B));
  end
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: multi-cycle branch resolver; decode handshake in, redirect/flush/resolve pulses and perf counters out
module branch_ctrl
  import br_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       funct3,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [XLEN-1:0]  A,
  input  logic [XLEN-1:0]  B,
  input  logic [XLEN-1:0]  target,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             resolve_valid,
  output logic             resolve_taken,
  output logic             misalign,
  output logic             illegal,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  br_state_t state, nextState;
  logic [2:0] f3Q;
  logic jalQ, jalrQ;
  logic [XLEN-1:0] aQ, bQ, targetQ, effTarget;
  logic [FCW-1:0] flushCnt;
  logic brUn, eq, lt, isJump, illegalBr, condTaken, taken, misAl, goRedirect, accept;

  branch_comp #(.XLEN(XLEN)) uComp (.A(aQ), .B(bQ), .BrUn(brUn), .Eq(eq), .Lt(lt));

  always_comb begin
    accept     = (state == IDLE) && br_valid;
    isJump     = jalQ | jalrQ;
    illegalBr  = !isJump && is_illegal_f3(f3Q);
    // bit 2 selects the Lt family, bit 0 inverts the sense
    condTaken  = f3Q[2] ? (lt ^ f3Q[0]) : (eq ^ f3Q[0]);
    taken      = isJump | (!illegalBr & condTaken);
    effTarget  = {targetQ[XLEN-1:1], targetQ[0] & !jalrQ};
    misAl      = taken && (effTarget[1:0] != 2'b00);
    goRedirect = taken && !misAl;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nextState;

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:     nextState = br_valid ? EVAL : IDLE;
      EVAL:     nextState = goRedirect ? REDIRECT : IDLE;
      REDIRECT: nextState = redirect_ready ? FLUSH : REDIRECT;
      FLUSH:    nextState = (flushCnt == FCW'(1)) ? IDLE : FLUSH;
      default:  nextState = IDLE;
    endcase
  end

  always_comb begin
    br_ready = state == IDLE;
    brUn     = f3Q[1];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      f3Q     <= '0;
      jalQ    <= 1'b0;
      jalrQ   <= 1'b0;
      aQ      <= '0;
      bQ      <= '0;
      targetQ <= '0;
    end else if (accept) begin
      f3Q     <= funct3;
      jalQ    <= is_jal;
      jalrQ   <= is_jalr;
      aQ      <= A;
      bQ      <= B;
      targetQ <= target;
    end

  // registered outputs are derived from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      flushCnt       <= '0;
      resolve_valid  <= 1'b0;
      resolve_taken  <= 1'b0;
      misalign       <= 1'b0;
      illegal        <= 1'b0;
      br_count       <= '0;
      taken_count    <= '0;
    end else begin
      redirect_valid <= nextState == REDIRECT;
      redirect_pc    <= (state == EVAL && goRedirect) ? effTarget : redirect_pc;
      flush          <= nextState == FLUSH;
      flushCnt       <= (state == REDIRECT && redirect_ready) ? FCW'(FLUSH_CYCLES) :
                        (state == FLUSH) ? flushCnt - 1'b1 : flushCnt;
      resolve_valid  <= state == EVAL;
      resolve_taken  <= state == EVAL && taken;
      misalign       <= state == EVAL && misAl;
      illegal        <= state == EVAL && illegalBr;
      br_count       <= accept ? br_count + CNT_W'(1) : br_count;
      taken_count    <= (state == EVAL && goRedirect) ? taken_count + CNT_W'(1) : taken_count;
    end
endmodule
